// File: rtl/ir_nec_transmitter.sv
// ---------------------------------------------------------------------------
// ir_nec_transmitter
//
// NEC-protocol infrared transmitter. A 32-bit word is latched on a start
// request and sent as a full NEC frame: 16-unit leader mark, 8-unit leader
// space, 32 data bits LSB first (1-unit mark plus a 1-unit space for a 0 or a
// 3-unit space for a 1), then a 1-unit stop mark. The envelope output is high
// during every mark. The IR output is the envelope gated by a carrier with a
// duty cycle of about 1/3.
//
// Optional build macro: IR_TX_REPEAT_EN
//   Adds i_REPEAT. If i_REPEAT is high when a stop burst ends, NEC repeat
//   codes (16-unit mark, 4-unit space, 1-unit mark) are sent. Each repeat
//   starts 196 units after the previous mark sequence started.
//
// Ports:
//   i_CLOCK_POS    system clock, rising edge
//   i_RESET_POS    asynchronous active-high reset
//   i_START        one-cycle send request, only sampled when idle
//   i_DATA[31:0]   frame payload, bit 0 is sent first
//   i_REPEAT       (IR_TX_REPEAT_EN only) keep sending repeat codes
//   o_BUSY         frame in progress
//   o_DONE         one-cycle pulse after the frame ends
//   o_IR_ENVELOPE  registered mark envelope
//   o_IR_TX        registered carrier-modulated LED drive
// ---------------------------------------------------------------------------
module ir_nec_transmitter #(
    parameter int UNIT_CYCLES    = 28125,
    parameter int CARRIER_PERIOD = 1316,
    parameter int CARRIER_HIGH   = 439
) (
    input  logic        i_CLOCK_POS,
    input  logic        i_RESET_POS,
    input  logic        i_START,
    input  logic [31:0] i_DATA,
`ifdef IR_TX_REPEAT_EN
    input  logic        i_REPEAT,
`endif
    output logic        o_BUSY,
    output logic        o_DONE,
    output logic        o_IR_ENVELOPE,
    output logic        o_IR_TX
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int PW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;

    localparam logic [UW-1:0] UNIT_LAST    = UW'(UNIT_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_LAST   = PW'(CARRIER_PERIOD - 1);
    localparam logic [PW-1:0] PHASE_HIGH   = PW'(CARRIER_HIGH);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LEAD_MARK  = 4'd1;
    localparam logic [3:0] S_LEAD_SPACE = 4'd2;
    localparam logic [3:0] S_BIT_MARK   = 4'd3;
    localparam logic [3:0] S_BIT_SPACE  = 4'd4;
    localparam logic [3:0] S_STOP_MARK  = 4'd5;
    localparam logic [3:0] S_DONE       = 4'd6;
`ifdef IR_TX_REPEAT_EN
    localparam logic [3:0] S_REPEAT_GAP = 4'd7;
    localparam logic [3:0] S_REP_MARK   = 4'd8;
    localparam logic [3:0] S_REP_SPACE  = 4'd9;
    localparam logic [3:0] S_REP_STOP   = 4'd10;
    // Repeat codes start every 196 units, counted from the previous mark start.
    localparam logic [7:0] REPEAT_LAST_UNIT = 8'd195;
`endif

    logic [3:0]    state_q,    state_d;
    logic [31:0]   shift_q,    shift_d;
    logic [4:0]    bit_idx_q,  bit_idx_d;
    logic [UW-1:0] unit_cnt_q, unit_cnt_d;
    logic [4:0]    dur_cnt_q,  dur_cnt_d;
    logic [PW-1:0] phase_q,    phase_d;
    logic          env_q,      env_d;
    logic          tx_q,       tx_d;
`ifdef IR_TX_REPEAT_EN
    logic [7:0]    frame_units_q, frame_units_d;
`endif

    logic       active;
    logic       unit_tick;
    logic [4:0] dur_last;
    logic       state_done;
    logic       mark_d;

    function automatic logic is_mark(input logic [3:0] s);
        logic m;
        m = (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
`ifdef IR_TX_REPEAT_EN
        m = m || (s == S_REP_MARK) || (s == S_REP_STOP);
`endif
        return m;
    endfunction

    always_comb begin
        active    = (state_q != S_IDLE) && (state_q != S_DONE);
        unit_tick = active && (unit_cnt_q == UNIT_LAST);

        // Last value of the unit-tick counter for the current state
        dur_last = 5'd0;
        case (state_q)
            S_LEAD_MARK:  dur_last = 5'd15;
            S_LEAD_SPACE: dur_last = 5'd7;
            S_BIT_SPACE:  dur_last = shift_q[0] ? 5'd2 : 5'd0;
`ifdef IR_TX_REPEAT_EN
            S_REP_MARK:   dur_last = 5'd15;
            S_REP_SPACE:  dur_last = 5'd3;
`endif
            default:      dur_last = 5'd0;
        endcase
        state_done = unit_tick && (dur_cnt_q == dur_last);

        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;

        case (state_q)
            S_IDLE: begin
                if (i_START) begin
                    shift_d   = i_DATA;
                    bit_idx_d = 5'd0;
                    state_d   = S_LEAD_MARK;
                end
            end
            S_LEAD_MARK:  if (state_done) state_d = S_LEAD_SPACE;
            S_LEAD_SPACE: if (state_done) state_d = S_BIT_MARK;
            S_BIT_MARK:   if (state_done) state_d = S_BIT_SPACE;
            S_BIT_SPACE: begin
                if (state_done) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 5'd1;
                    state_d   = (bit_idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                end
            end
            S_STOP_MARK: begin
                if (state_done) begin
`ifdef IR_TX_REPEAT_EN
                    state_d = i_REPEAT ? S_REPEAT_GAP : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IR_TX_REPEAT_EN
            S_REPEAT_GAP: begin
                if (unit_tick && (frame_units_q == REPEAT_LAST_UNIT))
                    state_d = S_REP_MARK;
            end
            S_REP_MARK:  if (state_done) state_d = S_REP_SPACE;
            S_REP_SPACE: if (state_done) state_d = S_REP_STOP;
            S_REP_STOP: begin
                if (state_done) state_d = i_REPEAT ? S_REPEAT_GAP : S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Every state change lands on a unit boundary, so the unit counter
        // only needs to wrap on its own tick.
        unit_cnt_d = (!active || unit_tick) ? '0 : unit_cnt_q + UW'(1);

        if (state_d != state_q)
            dur_cnt_d = 5'd0;
        else if (unit_tick)
            dur_cnt_d = dur_cnt_q + 5'd1;
        else
            dur_cnt_d = dur_cnt_q;

`ifdef IR_TX_REPEAT_EN
        if ((state_d != state_q) && ((state_d == S_LEAD_MARK) || (state_d == S_REP_MARK)))
            frame_units_d = 8'd0;
        else if (unit_tick)
            frame_units_d = frame_units_q + 8'd1;
        else
            frame_units_d = frame_units_q;
`endif

        // Carrier phase restarts on entry to each mark so that every burst
        // opens with a full high phase; it stays at 0 outside marks.
        mark_d = is_mark(state_d);
        if (!mark_d || (state_d != state_q))
            phase_d = '0;
        else if (phase_q == PHASE_LAST)
            phase_d = '0;
        else
            phase_d = phase_q + PW'(1);

        env_d = mark_d;
        tx_d  = mark_d && (phase_d < PHASE_HIGH);
    end

    always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
        if (i_RESET_POS) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            unit_cnt_q <= '0;
            dur_cnt_q  <= '0;
            phase_q    <= '0;
            env_q      <= 1'b0;
            tx_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            unit_cnt_q <= unit_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            phase_q    <= phase_d;
            env_q      <= env_d;
            tx_q       <= tx_d;
        end
    end

`ifdef IR_TX_REPEAT_EN
    always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
        if (i_RESET_POS) frame_units_q <= '0;
        else             frame_units_q <= frame_units_d;
    end
`endif

    assign o_BUSY        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_DONE        = (state_q == S_DONE);
    assign o_IR_ENVELOPE = env_q;
    assign o_IR_TX       = tx_q;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// ---------------------------------------------------------------------------
// tb_ir_nec_transmitter
//
// Directed bench for ir_nec_transmitter with UNIT_CYCLES=10,
// CARRIER_PERIOD=4, CARRIER_HIGH=1. Offsets k count cycles from the first
// cycle after the accepting edge (k=0 is the first leader-mark cycle).
// ---------------------------------------------------------------------------
module tb_ir_nec_transmitter;

    logic        clk = 1'b0;
    logic        i_RESET_POS;
    logic        i_START;
    logic [31:0] i_DATA;
`ifdef IR_TX_REPEAT_EN
    logic        i_REPEAT;
`endif
    logic        o_BUSY;
    logic        o_DONE;
    logic        o_IR_ENVELOPE;
    logic        o_IR_TX;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ir_nec_transmitter #(
        .UNIT_CYCLES   (10),
        .CARRIER_PERIOD(4),
        .CARRIER_HIGH  (1)
    ) dut (
        .i_CLOCK_POS  (clk),
        .i_RESET_POS  (i_RESET_POS),
        .i_START      (i_START),
        .i_DATA       (i_DATA),
`ifdef IR_TX_REPEAT_EN
        .i_REPEAT     (i_REPEAT),
`endif
        .o_BUSY       (o_BUSY),
        .o_DONE       (o_DONE),
        .o_IR_ENVELOPE(o_IR_ENVELOPE),
        .o_IR_TX      (o_IR_TX)
    );

    // Frame length in clocks: (89 + 2*ones) units of 10 clocks.
    function automatic int frame_len(input logic [31:0] d);
        return 890 + 20 * $countones(d);
    endfunction

    // Expected envelope / IR output at offset k of a frame carrying d.
    task automatic model(input logic [31:0] d, input int k, output logic e, output logic x);
        int s;
        e = 1'b0;
        x = 1'b0;
        if (k < 0) return;
        if (k < 160) begin
            e = 1'b1;
            x = ((k % 4) == 0);
            return;
        end
        s = 240;
        for (int i = 0; i < 32; i++) begin
            if (k >= s && k < s + 10) begin
                e = 1'b1;
                x = (((k - s) % 4) == 0);
                return;
            end
            s = s + 10 + (d[i] ? 30 : 10);
        end
        if (k >= s && k < s + 10) begin
            e = 1'b1;
            x = (((k - s) % 4) == 0);
        end
    endtask

    // Sends d from the current negedge and observes the frame through the
    // first idle cycle after DONE. Optionally pulses i_START with gd at
    // offset glitch_k. Returns mismatch tallies and the decoded envelope.
    task automatic run_frame(input logic [31:0] d, input int glitch_k, input logic [31:0] gd,
                             output int env_err, output int tx_err, output int busy_err,
                             output int busy_cnt, output int done_cnt, output int done_k,
                             output logic [31:0] dec);
        int   len;
        int   low_run;
        int   nbits;
        logic e, x, prev;
        len      = frame_len(d);
        env_err  = 0;
        tx_err   = 0;
        busy_err = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_k   = -1;
        dec      = '0;
        nbits    = 0;
        low_run  = 0;
        prev     = 1'b1;
        i_DATA   = d;
        i_START  = 1'b1;
        @(negedge clk);
        i_START  = 1'b0;
        for (int k = 0; k <= len + 1; k++) begin
            if (k == glitch_k) begin
                i_START = 1'b1;
                i_DATA  = gd;
            end else if (k == glitch_k + 1) begin
                i_START = 1'b0;
            end
            model(d, k, e, x);
            if (o_IR_ENVELOPE !== e) env_err++;
            if (o_IR_TX !== x) tx_err++;
            if (o_BUSY !== (k < len)) busy_err++;
            if (o_BUSY === 1'b1) busy_cnt++;
            if (o_DONE === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (o_IR_ENVELOPE === 1'b1) begin
                if (prev == 1'b0 && nbits < 32 && (low_run == 10 || low_run == 30)) begin
                    dec   = {(low_run == 30), dec[31:1]};
                    nbits = nbits + 1;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev = o_IR_ENVELOPE;
            if (k <= len) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int stray;
        i_RESET_POS = 1'b1;
        i_START     = 1'b0;
        i_DATA      = '0;
`ifdef IR_TX_REPEAT_EN
        i_REPEAT    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (o_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_BUSY); end
        checks++; if (o_DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_DONE); end
        checks++; if (o_IR_ENVELOPE !== 1'b0) begin failures++; $display("FAIL reset_env got=%b exp=0", o_IR_ENVELOPE); end
        checks++; if (o_IR_TX !== 1'b0) begin failures++; $display("FAIL reset_tx got=%b exp=0", o_IR_TX); end
        i_RESET_POS = 1'b0;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_BUSY !== 1'b0 || o_DONE !== 1'b0 || o_IR_ENVELOPE !== 1'b0 || o_IR_TX !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL idle_outputs active_cycles=%0d exp=0", stray); end
    endtask

    task automatic test_zero_frame();
        int ee, te, be, bc, dc, dk;
        logic [31:0] dec;
        run_frame(32'h0000_0000, -10, '0, ee, te, be, bc, dc, dk, dec);
        checks++; if (ee !== 0) begin failures++; $display("FAIL zero_env mismatches=%0d exp=0", ee); end
        checks++; if (te !== 0) begin failures++; $display("FAIL zero_tx mismatches=%0d exp=0", te); end
        checks++; if (be !== 0) begin failures++; $display("FAIL zero_busy mismatches=%0d exp=0", be); end
        checks++; if (bc !== 890) begin failures++; $display("FAIL zero_busy_len got=%0d exp=890", bc); end
        checks++; if (dk !== 890) begin failures++; $display("FAIL zero_done_at got=%0d exp=890", dk); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", dc); end
        checks++; if (dec !== 32'h0000_0000) begin failures++; $display("FAIL zero_decode got=%h exp=00000000", dec); end
    endtask

    task automatic test_ones_frame();
        int ee, te, be, bc, dc, dk;
        logic [31:0] dec;
        run_frame(32'hFFFF_FFFF, -10, '0, ee, te, be, bc, dc, dk, dec);
        checks++; if (ee !== 0) begin failures++; $display("FAIL ones_env mismatches=%0d exp=0", ee); end
        checks++; if (te !== 0) begin failures++; $display("FAIL ones_tx mismatches=%0d exp=0", te); end
        checks++; if (bc !== 1530) begin failures++; $display("FAIL ones_busy_len got=%0d exp=1530", bc); end
        checks++; if (dk !== 1530) begin failures++; $display("FAIL ones_done_at got=%0d exp=1530", dk); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL ones_done_count got=%0d exp=1", dc); end
        checks++; if (dec !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ones_decode got=%h exp=ffffffff", dec); end
    endtask

    task automatic test_ignore_start();
        int ee, te, be, bc, dc, dk;
        logic [31:0] dec;
        run_frame(32'h00FF_00FF, 600, 32'h1234_5678, ee, te, be, bc, dc, dk, dec);
        checks++; if (ee !== 0) begin failures++; $display("FAIL busy_start_env mismatches=%0d exp=0", ee); end
        checks++; if (be !== 0) begin failures++; $display("FAIL busy_start_busy mismatches=%0d exp=0", be); end
        checks++; if (dk !== 1210) begin failures++; $display("FAIL busy_start_done_at got=%0d exp=1210", dk); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dc); end
        checks++; if (dec !== 32'h00FF_00FF) begin failures++; $display("FAIL busy_start_decode got=%h exp=00ff00ff", dec); end
    endtask

    task automatic test_back_to_back();
        int ee, te, be, bc, dc, dk;
        logic [31:0] dec;
        run_frame(32'h0000_000F, -10, '0, ee, te, be, bc, dc, dk, dec);
        checks++; if (dk !== 970) begin failures++; $display("FAIL b2b_first_done_at got=%0d exp=970", dk); end
        checks++; if (dec !== 32'h0000_000F) begin failures++; $display("FAIL b2b_first_decode got=%h exp=0000000f", dec); end
        run_frame(32'h8000_0000, -10, '0, ee, te, be, bc, dc, dk, dec);
        checks++; if (ee !== 0) begin failures++; $display("FAIL b2b_second_env mismatches=%0d exp=0", ee); end
        checks++; if (te !== 0) begin failures++; $display("FAIL b2b_second_tx mismatches=%0d exp=0", te); end
        checks++; if (dk !== 910) begin failures++; $display("FAIL b2b_second_done_at got=%0d exp=910", dk); end
        checks++; if (dec !== 32'h8000_0000) begin failures++; $display("FAIL b2b_second_decode got=%h exp=80000000", dec); end
    endtask

    task automatic test_reset_midframe();
        int ee, te, be, bc, dc, dk, stray;
        logic [31:0] dec;
        i_DATA  = 32'hA5A5_A5A5;
        i_START = 1'b1;
        @(negedge clk);
        i_START = 1'b0;
        repeat (500) @(negedge clk);
        i_RESET_POS = 1'b1;
        #1;
        checks++; if (o_BUSY !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", o_BUSY); end
        checks++; if (o_DONE !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", o_DONE); end
        checks++; if (o_IR_ENVELOPE !== 1'b0) begin failures++; $display("FAIL midreset_env got=%b exp=0", o_IR_ENVELOPE); end
        checks++; if (o_IR_TX !== 1'b0) begin failures++; $display("FAIL midreset_tx got=%b exp=0", o_IR_TX); end
        stray = 0;
        for (int k = 0; k < 1400; k++) begin
            @(negedge clk);
            if (k == 2) i_RESET_POS = 1'b0;
            if (o_BUSY !== 1'b0 || o_DONE !== 1'b0 || o_IR_ENVELOPE !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL midreset_aborted active_cycles=%0d exp=0", stray); end
        run_frame(32'h1234_5678, -10, '0, ee, te, be, bc, dc, dk, dec);
        checks++; if (ee !== 0) begin failures++; $display("FAIL after_reset_env mismatches=%0d exp=0", ee); end
        checks++; if (te !== 0) begin failures++; $display("FAIL after_reset_tx mismatches=%0d exp=0", te); end
        checks++; if (dk !== 1150) begin failures++; $display("FAIL after_reset_done_at got=%0d exp=1150", dk); end
        checks++; if (dec !== 32'h1234_5678) begin failures++; $display("FAIL after_reset_decode got=%h exp=12345678", dec); end
    endtask

`ifdef IR_TX_REPEAT_EN
    task automatic test_repeat();
        int   ee, te, dc, dk, bc, rel, base;
        logic e, x;
        ee = 0; te = 0; dc = 0; dk = -1; bc = 0;
        i_REPEAT = 1'b1;
        i_DATA   = 32'h0000_0000;
        i_START  = 1'b1;
        @(negedge clk);
        i_START  = 1'b0;
        for (int k = 0; k <= 4132; k++) begin
            if (k == 2500) i_REPEAT = 1'b0;
            model(32'h0000_0000, k, e, x);
            base = (k >= 3920) ? 3920 : 1960;
            rel  = k - base;
            if (k >= 1960 && rel < 210) begin
                e = (rel < 160) || (rel >= 200);
                x = e && ((rel < 160) ? ((rel % 4) == 0) : (((rel - 200) % 4) == 0));
            end
            if (o_IR_ENVELOPE !== e) ee++;
            if (o_IR_TX !== x) te++;
            if (o_BUSY === 1'b1) bc++;
            if (o_DONE === 1'b1) begin
                dc++;
                if (dk < 0) dk = k;
            end
            @(negedge clk);
        end
        checks++; if (ee !== 0) begin failures++; $display("FAIL repeat_env mismatches=%0d exp=0", ee); end
        checks++; if (te !== 0) begin failures++; $display("FAIL repeat_tx mismatches=%0d exp=0", te); end
        checks++; if (bc !== 4130) begin failures++; $display("FAIL repeat_busy_len got=%0d exp=4130", bc); end
        checks++; if (dk !== 4130) begin failures++; $display("FAIL repeat_done_at got=%0d exp=4130", dk); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL repeat_done_count got=%0d exp=1", dc); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_frame();
        test_ones_frame();
        test_ignore_start();
        test_back_to_back();
        test_reset_midframe();
`ifdef IR_TX_REPEAT_EN
        test_repeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
